// File: rtl/serial_fafs_unit.sv
// Bit-serial WIDTH-bit adder/subtractor sequencing a one-bit full-adder/full-subtractor cell.
module serial_fafs_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic sumdiff_c, carry_c, borrow_c, cnext_c;

  // One-bit full-adder/full-subtractor cell on the operand LSBs
  always_comb begin
    sumdiff_c = a_q[0] ^ b_q[0] ^ c_q;
    carry_c   = (a_q[0] & b_q[0]) | (b_q[0] & c_q) | (a_q[0] & c_q);
    borrow_c  = (~a_q[0] & b_q[0]) | (b_q[0] & c_q) | (~a_q[0] & c_q);
    cnext_c   = mode_q ? borrow_c : carry_c;
  end

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    mode_d   = mode_q;
    result_d = result_q;
    cout_d   = cout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = opa;
          b_d     = opb;
          mode_d  = sub;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        p_d   = {sumdiff_c, p_q[WIDTH-1:1]};
        c_d   = cnext_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the completed word and final carry/borrow
          result_d = {sumdiff_c, p_q[WIDTH-1:1]};
          cout_d   = cnext_c;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_fafs_unit.sv
// Directed and sweep checks for the bit-serial adder/subtractor.
module tb_serial_fafs_unit;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  int tests;
  int fails;

  serial_fafs_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .opa    (opa),
    .opb    (opb),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation from IDLE and wait (bounded) for its done pulse.
  // Returns result/cout at done, latency in edges, and done/busy one cycle later.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       output logic [WIDTH-1:0] r, output logic co, output int lat,
                       output logic done_next, output logic busy_next);
    lat = -1;
    r = '0;
    co = 1'b0;
    @(negedge clk);
    opa = a;
    opb = b;
    sub = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (done) lat = 0;
    for (int k = 1; k <= WIDTH + 6 && lat < 0; k++) begin
      if (k > 1) begin
        @(posedge clk);
        @(negedge clk);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      if (done) begin
        lat = k;
        r = result;
        co = cout;
      end
    end
    @(posedge clk);
    @(negedge clk);
    done_next = done;
    busy_next = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    opa = '0;
    opb = '0;
    #2;
    tests++;
    if ({busy, done, result, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b, want all zero",
               busy, done, result, cout);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [WIDTH-1:0] r;
    logic co, dn, bz;
    int lat;
    logic [WIDTH-1:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [WIDTH-1:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
    logic [WIDTH-1:0] vr [3] = '{8'h96, 8'h00, 8'hFE};
    logic             vc [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b0, r, co, lat, dn, bz);
      tests++;
      if (lat !== WIDTH) begin
        fails++;
        $display("FAIL add_latency[%0d]: got %0d, want %0d", i, lat, WIDTH);
      end
      tests++;
      if ({r, co} !== {vr[i], vc[i]}) begin
        fails++;
        $display("FAIL add_value[%0d] %h+%h: got result=%h cout=%b, want result=%h cout=%b",
                 i, va[i], vb[i], r, co, vr[i], vc[i]);
      end
      tests++;
      if ({dn, bz} !== 2'b00) begin
        fails++;
        $display("FAIL add_after_done[%0d]: got done=%b busy=%b, want 0 0", i, dn, bz);
      end
    end
  endtask

  task automatic test_sub();
    logic [WIDTH-1:0] r;
    logic co, dn, bz;
    int lat;
    do_op(8'h10, 8'h01, 1'b1, r, co, lat, dn, bz);
    tests++;
    if ({r, co} !== {8'h0F, 1'b0} || lat !== WIDTH) begin
      fails++;
      $display("FAIL sub_basic: got result=%h cout=%b lat=%0d, want 0f 0 lat=%0d", r, co, lat, WIDTH);
    end
    do_op(8'h01, 8'h02, 1'b1, r, co, lat, dn, bz);
    tests++;
    if ({r, co} !== {8'hFF, 1'b1} || lat !== WIDTH) begin
      fails++;
      $display("FAIL sub_underflow: got result=%h cout=%b lat=%0d, want ff 1 lat=%0d", r, co, lat, WIDTH);
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    int bad_hold;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] got;
    logic got_c;
    prev = result;
    ndone = 0;
    bad_hold = 0;
    got = '0;
    got_c = 1'b1;
    @(negedge clk);
    opa = 8'h12;
    opb = 8'h34;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      if (k == 3) begin
        opa = 8'h00;
        opb = 8'h00;
        sub = 1'b1;
        start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        got = result;
        got_c = cout;
      end else if (ndone == 0 && result !== prev) begin
        bad_hold++;
      end
    end
    tests++;
    if (ndone !== 1) begin
      fails++;
      $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", ndone);
    end
    tests++;
    if ({got, got_c} !== {8'h46, 1'b0}) begin
      fails++;
      $display("FAIL ignore_start_value: got result=%h cout=%b, want 46 0", got, got_c);
    end
    tests++;
    if (bad_hold !== 0) begin
      fails++;
      $display("FAIL result_hold: got %0d cycles with changed result, want 0", bad_hold);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    logic [WIDTH-1:0] r;
    logic co, dn, bz;
    int lat;
    ndone = 0;
    @(negedge clk);
    opa = 8'h77;
    opb = 8'h11;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, result, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b result=%h cout=%b, want all zero",
               busy, done, result, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL reset_abort: got %0d cycles with done/busy, want 0", ndone);
    end
    do_op(8'h80, 8'h80, 1'b1, r, co, lat, dn, bz);
    tests++;
    if ({r, co} !== {8'h00, 1'b0} || lat !== WIDTH) begin
      fails++;
      $display("FAIL after_reset_sub: got result=%h cout=%b lat=%0d, want 00 0 lat=%0d", r, co, lat, WIDTH);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int bad_pos;
    int n_result_bad;
    logic prev_done;
    ndone = 0;
    bad_pos = 0;
    n_result_bad = 0;
    prev_done = 1'b0;
    @(negedge clk);
    opa = 8'h03;
    opb = 8'h04;
    sub = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (prev_done || ((i - WIDTH) % (WIDTH + 2)) != 0) bad_pos++;
        if ({result, cout} !== {8'h07, 1'b0}) n_result_bad++;
      end
      if (i == 0 && !busy) bad_pos++;
      prev_done = done;
    end
    start = 1'b0;
    repeat (WIDTH + 3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (ndone !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", ndone);
    end
    tests++;
    if (bad_pos !== 0 || n_result_bad !== 0) begin
      fails++;
      $display("FAIL b2b_timing: got %0d misplaced pulses, %0d bad results, want 0 0", bad_pos, n_result_bad);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, r, er;
    logic s, co, ec, dn, bz;
    int lat;
    logic [WIDTH:0] wide;
    for (int i = 0; i < 500; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      s = 1'($urandom);
      if (s) begin
        er = WIDTH'(a - b);
        ec = (a < b);
      end else begin
        wide = {1'b0, a} + {1'b0, b};
        er = wide[WIDTH-1:0];
        ec = wide[WIDTH];
      end
      do_op(a, b, s, r, co, lat, dn, bz);
      tests++;
      if ({r, co} !== {er, ec} || lat !== WIDTH) begin
        fails++;
        $display("FAIL random[%0d] a=%h b=%h sub=%b: got result=%h cout=%b lat=%0d, want %h %b lat=%0d",
                 i, a, b, s, r, co, lat, er, ec, WIDTH);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
